// File: rtl/layer0_counter_act_if.sv
// Layer-0 support bundle: MAC step ack in, done flag out, two pre-activations in, two activations out.
// Pure wiring, no latency; no backpressure, every signal is sampled or driven each cycle.
// master = MAC engine / layer datapath side, slave = counter/activation block.
interface layer0_counter_act_if;
    logic              ack;
    logic              ack_mac;
    logic signed [7:0] z_value0;
    logic signed [7:0] z_value1;
    logic signed [7:0] a0;
    logic signed [7:0] a1;

    modport master (
        output ack,
        output z_value0,
        output z_value1,
        input  ack_mac,
        input  a0,
        input  a1
    );

    modport slave (
        input  ack,
        input  z_value0,
        input  z_value1,
        output ack_mac,
        output a0,
        output a1
    );
endinterface

// File: rtl/layer0_counter_act.sv
// Layer-0 MAC step counter plus sigmoid-ish (func0) and ReLU (func1) activations, Q4.4 data.
// Latency: ack_mac one cycle after the N_INPUTS-th ack; a0/a1 combinational, zero cycles.
// Backpressure: none; ack pulses after completion are dropped until the next rst.
module layer0_counter_act #(
    parameter int N_INPUTS = 2,
    parameter int CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    layer0_counter_act_if.slave  io
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ack_mac_q;
    logic             ack_mac_d;

    // Once done, the counter freezes so the flag cannot wrap back low.
    always_comb begin
        cnt_d     = cnt_q;
        ack_mac_d = ack_mac_q;
        if (io.ack && !ack_mac_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                ack_mac_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ack_mac_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ack_mac_q <= ack_mac_d;
        end
    end

    assign io.ack_mac = ack_mac_q;

    logic signed [8:0] z0_ext;
    logic signed [8:0] t0;

    // func0: clamp(z/4 + 0.5, 0, 1); 9 bits so the +8 bias cannot overflow.
    always_comb begin
        z0_ext = {io.z_value0[7], io.z_value0};
        t0     = (z0_ext >>> 2) + 9'sd8;
        if (t0 < 9'sd0) begin
            io.a0 = 8'sd0;
        end else if (t0 > 9'sd16) begin
            io.a0 = 8'sd16;
        end else begin
            io.a0 = t0[7:0];
        end
    end

    // func1: ReLU; sign bit set (including -128) maps to zero.
    always_comb begin
        if (io.z_value1[7]) begin
            io.a1 = 8'sd0;
        end else begin
            io.a1 = io.z_value1;
        end
    end

endmodule

// File: tb/tb_layer0_counter_act.sv
// Directed bench for layer0_counter_act: counter sequencing, reset priority, activation points and sweep.
module tb_layer0_counter_act;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    layer0_counter_act_if io ();

    layer0_counter_act #(
        .N_INPUTS (2),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive ack for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic a);
        io.ack = a;
        @(posedge clk);
        #1;
        io.ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        io.z_value0 = 8'sd0;
        io.z_value1 = 8'sd0;
        rst = 1'b1;
        step(1'b0);
        n_cmp++;
        if (io.ack_mac !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ack_mac got=%b want=0", io.ack_mac);
        end
        n_cmp++;
        if (dut.cnt_q !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_cnt got=%0d want=0", dut.cnt_q);
        end
        io.z_value0 = 8'sd19;
        io.z_value1 = 8'sd19;
        #1;
        n_cmp++;
        if (io.a0 !== 8'sd12) begin
            n_bad++;
            $display("FAIL reset_a0 got=%0d want=12", io.a0);
        end
        n_cmp++;
        if (io.a1 !== 8'sd19) begin
            n_bad++;
            $display("FAIL reset_a1 got=%0d want=19", io.a1);
        end
        rst = 1'b0;
    endtask

    task automatic test_counter_basic();
        logic exp;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            step((c == 3) || (c == 6));
            exp = (c >= 6);
            n_cmp++;
            if (io.ack_mac !== exp) begin
                n_bad++;
                $display("FAIL basic_cycle%0d got=%b want=%b", c + 1, io.ack_mac, exp);
            end
        end
    endtask

    task automatic test_hold_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            n_cmp++;
            if (io.ack_mac !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_pulse%0d got=%b want=1", k, io.ack_mac);
            end
        end
        n_cmp++;
        if (dut.cnt_q !== 2'd2) begin
            n_bad++;
            $display("FAIL hold_cnt got=%0d want=2", dut.cnt_q);
        end
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        n_cmp++;
        if (io.ack_mac !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_vs_ack_flag got=%b want=0", io.ack_mac);
        end
        n_cmp++;
        if (dut.cnt_q !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_vs_ack_cnt got=%0d want=0", dut.cnt_q);
        end
        step(1'b1);
        n_cmp++;
        if (io.ack_mac !== 1'b0 || dut.cnt_q !== 2'd1) begin
            n_bad++;
            $display("FAIL rearm_first got=%b/%0d want=0/1", io.ack_mac, dut.cnt_q);
        end
        step(1'b0);
        n_cmp++;
        if (io.ack_mac !== 1'b0) begin
            n_bad++;
            $display("FAIL rearm_idle got=%b want=0", io.ack_mac);
        end
        step(1'b1);
        n_cmp++;
        if (io.ack_mac !== 1'b1) begin
            n_bad++;
            $display("FAIL rearm_second got=%b want=1", io.ack_mac);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1);
        n_cmp++;
        if (io.ack_mac !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first got=%b want=0", io.ack_mac);
        end
        step(1'b1);
        n_cmp++;
        if (io.ack_mac !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second got=%b want=1", io.ack_mac);
        end
        step(1'b0);
        n_cmp++;
        if (io.ack_mac !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_hold got=%b want=1", io.ack_mac);
        end
    endtask

    task automatic test_func0_points();
        logic signed [7:0] zin [7] = '{-8'sd7, 8'sd19, 8'sd0, -8'sd40, 8'sd40, -8'sd128, 8'sd127};
        logic signed [7:0] aex [7] = '{8'sd6, 8'sd12, 8'sd8, 8'sd0, 8'sd16, 8'sd0, 8'sd16};
        for (int i = 0; i < 7; i++) begin
            io.z_value0 = zin[i];
            #1;
            n_cmp++;
            if (io.a0 !== aex[i]) begin
                n_bad++;
                $display("FAIL func0_z%0d got=%0d want=%0d", zin[i], io.a0, aex[i]);
            end
        end
    endtask

    task automatic test_func1_points();
        logic signed [7:0] zin [5] = '{-8'sd7, 8'sd19, 8'sd0, 8'sd127, -8'sd128};
        logic signed [7:0] aex [5] = '{8'sd0, 8'sd19, 8'sd0, 8'sd127, 8'sd0};
        for (int i = 0; i < 5; i++) begin
            io.z_value1 = zin[i];
            #1;
            n_cmp++;
            if (io.a1 !== aex[i]) begin
                n_bad++;
                $display("FAIL func1_z%0d got=%0d want=%0d", zin[i], io.a1, aex[i]);
            end
        end
    endtask

    // Reference uses integer floor division rather than a shift.
    task automatic test_sweep();
        byte zb;
        int  z;
        int  q;
        int  t;
        int  e0;
        int  e1;
        for (int i = 0; i < 256; i++) begin
            zb = byte'(i);
            z  = zb;
            q  = (z >= 0) ? (z / 4) : -((-z + 3) / 4);
            t  = q + 8;
            e0 = (t < 0) ? 0 : ((t > 16) ? 16 : t);
            e1 = (z > 0) ? z : 0;
            io.z_value0 = zb;
            io.z_value1 = zb;
            #1;
            n_cmp++;
            if (io.a0 !== 8'(e0)) begin
                n_bad++;
                $display("FAIL sweep_a0_z%0d got=%0d want=%0d", z, io.a0, e0);
            end
            n_cmp++;
            if (io.a1 !== 8'(e1)) begin
                n_bad++;
                $display("FAIL sweep_a1_z%0d got=%0d want=%0d", z, io.a1, e1);
            end
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        io.ack      = 1'b0;
        io.z_value0 = 8'sd0;
        io.z_value1 = 8'sd0;
        test_reset();
        test_counter_basic();
        test_hold_reset();
        test_back_to_back();
        test_func0_points();
        test_func1_points();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layer0_counter_act.md
# layer0_counter_act

Support logic for neural-network layer 0. It contains a MAC-step counter that tells the layer when all input products for the current sample have been accumulated. It also contains the layer's two activation functions, which map the biased pre-activations z0/z1 to outputs a0/a1. All data is 8-bit signed fixed-point with 4 fractional bits (Q4.4, 1.0 = 16).

## Interface
Parameters:
- N_INPUTS, default 2: number of MAC steps (one per layer input) per sample.
- CNT_W, default 2: counter width; must satisfy 2^CNT_W > N_INPUTS.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- ack  input  1  one-cycle pulse from the MAC engine; one pulse per completed multiply-accumulate step.
- ack_mac  output  1  registered; high once N_INPUTS steps have completed.
- z_value0  input  8 signed  pre-activation of neuron 0 (Q4.4).
- z_value1  input  8 signed  pre-activation of neuron 1 (Q4.4).
- a0  output  8 signed  activation of neuron 0; func0 is a piecewise-linear sigmoid.
- a1  output  8 signed  activation of neuron 1; func1 is ReLU.

## Operation
Counter:
- Register cnt (CNT_W bits) and register ack_mac.
- On a rising edge with rst=1: cnt <= 0 and ack_mac <= 0. Reset overrides every other input.
- On a rising edge with rst=0, ack=1 and ack_mac=0: cnt <= cnt+1. If cnt+1 == N_INPUTS, ack_mac <= 1 in the same edge.
- While ack_mac=1, further ack pulses are ignored. cnt and ack_mac hold until the next rst; there is no wrap-around.
- ack=0 holds state.

func0 (sigmoid approximation, combinational):
- t = (z_value0 >>> 2) + 8, using an arithmetic shift (floor) in at least 8-bit signed arithmetic.
- a0 = 0 if t < 0; a0 = 16 if t > 16; otherwise a0 = t.
- This approximates clamp(0.5 + z/4, 0, 1). The output range is 0..16.

func1 (ReLU, combinational):
- a1 = z_value1 if z_value1 > 0, else 0.
- The output range is 0..127. -128 maps to 0.

The activation functions hold no state and ignore clk and rst.

## Timing
- Reset values: cnt=0, ack_mac=0. a0 and a1 are always purely combinational functions of their inputs, so a0 = f0(z_value0) and a1 = f1(z_value1) during and after reset.
- ack_mac rises in the clock edge that samples the N_INPUTS-th ack pulse. It is visible in the cycle immediately after that edge.
- ack_mac stays high until the first edge at which rst=1; the following cycle shows 0.
- Simultaneous rst=1 and ack=1: reset wins and the pulse is not counted.
- Back-to-back ack pulses on consecutive cycles each count.
- a0 and a1 have zero-cycle latency: they follow their inputs within the same cycle, with no registers in the path.

## Test plan
- Counter basic: rst for 1 cycle, then ack pulses at cycles 3 and 6 -> ack_mac=0 through cycle 6, ack_mac=1 from cycle 7 onward.
- Counter hold/reset: after ack_mac=1, 3 further ack pulses -> ack_mac stays 1; then rst=1 with ack=1 on the same edge -> ack_mac=0 and cnt=0. Two more pulses are then required to raise ack_mac again.
- Back-to-back ack: ack high 2 consecutive cycles after reset -> ack_mac=1 on the cycle after the second pulse.
- func0 points: z_value0 = -7 -> 6; 19 -> 12; 0 -> 8; -40 -> 0; 40 -> 16; -128 -> 0; 127 -> 16.
- func1 points: z_value1 = -7 -> 0; 19 -> 19; 0 -> 0; 127 -> 127; -128 -> 0.
- Exhaustive sweep: all 256 values of z_value0 and z_value1 checked against the formulas above.
